// File: rtl/cmd_pkg.sv
// Shared constants, register map and state encodings for the UART command parser.
package cmd_pkg;

    localparam logic [7:0] C_HDR_WR = 8'h4B;
    localparam logic [7:0] C_HDR_RD = 8'hB4;
    localparam logic [7:0] C_TERM   = 8'h0D;
    localparam logic [7:0] C_ACK    = 8'h87;
    localparam logic [7:0] C_NAK    = 8'h78;

    // PWM register bank address map
    localparam logic [7:0] C_REG_INIT     = 8'h00;
    localparam logic [7:0] C_REG_EN_BASE  = 8'h02;
    localparam logic [7:0] C_REG_INC_BASE = 8'h0A;
    localparam logic [7:0] C_REG_DEC_BASE = 8'h12;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_PAYLOAD,
        ST_TERM,
        ST_COMMIT,
        ST_RD_ACK,
        ST_RD_FETCH,
        ST_RD_SEND,
        ST_RD_TRAIL,
        ST_WR_RESP
    } parser_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_WAIT_RISE,
        TX_WAIT_FALL
    } tx_state_t;

    // States in which a partially received frame can be abandoned by timeout
    function automatic logic is_rx_frame_state(input parser_state_t s);
        return (s == ST_ADDR) || (s == ST_LEN) || (s == ST_PAYLOAD) || (s == ST_TERM);
    endfunction

endpackage

// File: rtl/cmd_tx_seq.sv
// Single-byte UART send handshake: start pulse, then track busy rise and fall,
// then a one-cycle done pulse. Data stays on o_tx_data until busy falls.
module cmd_tx_seq
    import cmd_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_send,
    input  logic [7:0] i_data,
    input  logic       i_tx_busy,
    output logic [7:0] o_tx_data,
    output logic       o_tx_start,
    output logic       o_done
);

    tx_state_t  state_reg, state_next;
    logic [7:0] data_reg, data_next;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= TX_IDLE;
            data_reg  <= 8'h00;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        o_tx_start = 1'b0;
        o_done     = 1'b0;
        o_tx_data  = data_reg;
        case (state_reg)
            TX_IDLE: begin
                o_tx_data = 8'h00;
                if (i_send && !i_tx_busy && !i_rst) begin
                    o_tx_start = 1'b1;
                    o_tx_data  = i_data;
                    data_next  = i_data;
                    state_next = TX_WAIT_RISE;
                end
            end
            TX_WAIT_RISE: begin
                if (i_tx_busy) begin
                    state_next = TX_WAIT_FALL;
                end
            end
            TX_WAIT_FALL: begin
                if (!i_tx_busy) begin
                    o_done     = 1'b1;
                    state_next = TX_IDLE;
                end
            end
            default: state_next = TX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Host frame decoder: buffered register writes committed on terminator, register
// read-back streamed as ACK/data/trailer. CMD_PARSER_WR_ACK_EN adds write ACK/NAK.
module uart_cmd_parser
    import cmd_pkg::*;
#(
    parameter int g_MAX_LEN      = 16,
    parameter int g_TIMEOUT_CLKS = 300000,
    parameter int g_ADDR_W       = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [7:0]          i_rx_data,
    input  logic                i_rx_vld,
    output logic [7:0]          o_tx_data,
    output logic                o_tx_start,
    input  logic                i_tx_busy,
    output logic [g_ADDR_W-1:0] o_reg_addr,
    output logic [7:0]          o_reg_wdata,
    output logic                o_reg_we,
    output logic                o_reg_re,
    input  logic [7:0]          i_reg_rdata,
    output logic                o_frame_err
);

    localparam int IDX_W = $clog2(g_MAX_LEN);
    localparam int TO_W  = $clog2(g_TIMEOUT_CLKS + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(g_TIMEOUT_CLKS - 1);

`ifdef CMD_PARSER_WR_ACK_EN
    localparam parser_state_t ST_FAIL    = ST_WR_RESP;
    localparam parser_state_t ST_WR_DONE = ST_WR_RESP;
`else
    localparam parser_state_t ST_FAIL    = ST_IDLE;
    localparam parser_state_t ST_WR_DONE = ST_IDLE;
`endif

    parser_state_t       state_reg, state_next;
    logic                wr_reg, wr_next;
    logic [g_ADDR_W-1:0] start_reg, start_next;
    logic [7:0]          len_reg, len_next;
    logic [7:0]          idx_reg, idx_next;
    logic [TO_W-1:0]     to_cnt_reg, to_cnt_next;
    logic [1:0]          phase_reg, phase_next;
    logic [7:0]          rd_byte_reg, rd_byte_next;
    logic [7:0]          resp_reg, resp_next;
    logic                we_reg, we_next;
    logic                re_reg, re_next;
    logic [g_ADDR_W-1:0] addr_reg, addr_next;
    logic                err_reg, err_next;

    logic [7:0] pay_mem [g_MAX_LEN];
    logic [7:0] rd_q_reg;

    logic       send;
    logic [7:0] send_data;
    logic       tx_done;

    cmd_tx_seq u_tx_seq (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_send     (send),
        .i_data     (send_data),
        .i_tx_busy  (i_tx_busy),
        .o_tx_data  (o_tx_data),
        .o_tx_start (o_tx_start),
        .o_done     (tx_done)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg   <= ST_IDLE;
            wr_reg      <= 1'b0;
            start_reg   <= '0;
            len_reg     <= 8'h00;
            idx_reg     <= 8'h00;
            to_cnt_reg  <= '0;
            phase_reg   <= 2'd0;
            rd_byte_reg <= 8'h00;
            resp_reg    <= 8'h00;
            we_reg      <= 1'b0;
            re_reg      <= 1'b0;
            addr_reg    <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            wr_reg      <= wr_next;
            start_reg   <= start_next;
            len_reg     <= len_next;
            idx_reg     <= idx_next;
            to_cnt_reg  <= to_cnt_next;
            phase_reg   <= phase_next;
            rd_byte_reg <= rd_byte_next;
            resp_reg    <= resp_next;
            we_reg      <= we_next;
            re_reg      <= re_next;
            addr_reg    <= addr_next;
            err_reg     <= err_next;
        end
    end

    // Payload buffer; its registered read port doubles as the write-data output register
    always_ff @(posedge i_clk) begin
        if (state_reg == ST_PAYLOAD && i_rx_vld) begin
            pay_mem[idx_reg[IDX_W-1:0]] <= i_rx_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_q_reg <= 8'h00;
        end else if (state_reg == ST_COMMIT) begin
            rd_q_reg <= pay_mem[idx_reg[IDX_W-1:0]];
        end
    end

    always_comb begin
        state_next   = state_reg;
        wr_next      = wr_reg;
        start_next   = start_reg;
        len_next     = len_reg;
        idx_next     = idx_reg;
        to_cnt_next  = '0;
        phase_next   = phase_reg;
        rd_byte_next = rd_byte_reg;
        resp_next    = resp_reg;
        we_next      = 1'b0;
        re_next      = 1'b0;
        addr_next    = '0;
        err_next     = 1'b0;
        send         = 1'b0;
        send_data    = 8'h00;

        case (state_reg)
            ST_IDLE: begin
                if (i_rx_vld && i_rx_data == C_HDR_WR) begin
                    wr_next    = 1'b1;
                    state_next = ST_ADDR;
                end else if (i_rx_vld && i_rx_data == C_HDR_RD) begin
                    wr_next    = 1'b0;
                    state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (i_rx_vld) begin
                    start_next = g_ADDR_W'(i_rx_data);
                    state_next = ST_LEN;
                end
            end
            ST_LEN: begin
                if (i_rx_vld) begin
                    len_next = i_rx_data;
                    idx_next = 8'h00;
                    if (32'(i_rx_data) >= g_MAX_LEN) begin
                        err_next   = 1'b1;
                        resp_next  = C_NAK;
                        state_next = ST_FAIL;
                    end else begin
                        state_next = wr_reg ? ST_PAYLOAD : ST_RD_ACK;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (i_rx_vld) begin
                    if (idx_reg == len_reg) begin
                        idx_next   = 8'h00;
                        state_next = ST_TERM;
                    end else begin
                        idx_next = idx_reg + 8'd1;
                    end
                end
            end
            ST_TERM: begin
                if (i_rx_vld) begin
                    if (i_rx_data == C_TERM) begin
                        state_next = ST_COMMIT;
                    end else begin
                        err_next   = 1'b1;
                        resp_next  = C_NAK;
                        state_next = ST_FAIL;
                    end
                end
            end
            ST_COMMIT: begin
                we_next   = 1'b1;
                addr_next = start_reg + g_ADDR_W'(idx_reg);
                if (idx_reg == len_reg) begin
                    idx_next   = 8'h00;
                    resp_next  = C_ACK;
                    state_next = ST_WR_DONE;
                end else begin
                    idx_next = idx_reg + 8'd1;
                end
            end
            ST_RD_ACK: begin
                send      = 1'b1;
                send_data = C_ACK;
                if (tx_done) begin
                    phase_next = 2'd0;
                    state_next = ST_RD_FETCH;
                end
            end
            ST_RD_FETCH: begin
                // phase 0 issues the read, phase 2 is the cycle the data is valid
                case (phase_reg)
                    2'd0: begin
                        re_next    = 1'b1;
                        addr_next  = start_reg + g_ADDR_W'(idx_reg);
                        phase_next = 2'd1;
                    end
                    2'd1: phase_next = 2'd2;
                    default: begin
                        rd_byte_next = i_reg_rdata;
                        phase_next   = 2'd0;
                        state_next   = ST_RD_SEND;
                    end
                endcase
            end
            ST_RD_SEND: begin
                send      = 1'b1;
                send_data = rd_byte_reg;
                if (tx_done) begin
                    if (idx_reg == len_reg) begin
                        state_next = ST_RD_TRAIL;
                    end else begin
                        idx_next   = idx_reg + 8'd1;
                        state_next = ST_RD_FETCH;
                    end
                end
            end
            ST_RD_TRAIL: begin
                send      = 1'b1;
                send_data = C_TERM;
                if (tx_done) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WR_RESP: begin
                send      = 1'b1;
                send_data = resp_reg;
                if (tx_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // A byte arriving on the expiry cycle wins over the timeout
        if (is_rx_frame_state(state_reg) && !i_rx_vld) begin
            if (to_cnt_reg == TO_LAST) begin
                err_next   = 1'b1;
                idx_next   = 8'h00;
                state_next = ST_IDLE;
            end else begin
                to_cnt_next = to_cnt_reg + 1'b1;
            end
        end
    end

    assign o_reg_we    = we_reg;
    assign o_reg_re    = re_reg;
    assign o_reg_addr  = addr_reg;
    assign o_reg_wdata = we_reg ? rd_q_reg : 8'h00;
    assign o_frame_err = err_reg;

endmodule
